// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the CPU memory stage, the I/O transfer engine, the data RAM and the arbiter.
// The master side is the surrounding system, and the slave side is the arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          io_req;
  logic          io_we;
  logic          io_last;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata;
  logic          io_gnt;
  logic [DW-1:0] io_rdata;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output io_req, io_we, io_last, io_addr, io_wdata,
    input  io_gnt, io_rdata,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  io_req, io_we, io_last, io_addr, io_wdata,
    output io_gnt, io_rdata,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-port data RAM arbiter: the CPU has default priority, I/O bursts are locked,
// and an I/O request that has waited too long behind the CPU is forced through.
module ram_port_arbiter #(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned BURST_MAX    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_port_arbiter_if.slave  bus
);

  localparam int unsigned BEAT_W   = $clog2(BURST_MAX + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam bit          CAN_LOCK = (BURST_MAX > 1);

  typedef enum logic {S_CPU, S_IO} state_t;

  state_t              state, state_n;
  logic [BEAT_W-1:0]   beat_cnt, beat_n;
  logic [STARVE_W-1:0] starve_cnt, starve_n;

  logic          force_io;
  logic          cpu_gnt;
  logic          io_gnt;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  assign force_io = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CPU;
      beat_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_n;
      beat_cnt   <= beat_n;
      starve_cnt <= starve_n;
    end
  end

  // Next state: burst lock tracking and starvation counter
  always_comb begin
    state_n  = state;
    beat_n   = beat_cnt;
    starve_n = starve_cnt;
    unique case (state)
      S_CPU: begin
        if (io_gnt && !bus.io_last && CAN_LOCK) begin
          state_n = S_IO;
          beat_n  = BEAT_W'(1);
        end
      end
      S_IO: begin
        // A dropped request abandons the burst just like its final beat does.
        if (!bus.io_req || bus.io_last || (beat_cnt == BEAT_W'(BURST_MAX - 1))) begin
          state_n = S_CPU;
          beat_n  = '0;
        end else begin
          beat_n = beat_cnt + BEAT_W'(1);
        end
      end
      default: begin
        state_n = S_CPU;
        beat_n  = '0;
      end
    endcase
    if (io_gnt || !bus.io_req) begin
      starve_n = '0;
    end else if (!force_io) begin
      starve_n = starve_cnt + STARVE_W'(1);
    end
  end

  // Grants: combinational from state and requests, all suppressed while in reset
  always_comb begin
    cpu_gnt = 1'b0;
    io_gnt  = 1'b0;
    if (rst_n) begin
      if (state == S_IO) begin
        io_gnt = bus.io_req;
      end else begin
        cpu_gnt = bus.cpu_req && !force_io;
        io_gnt  = !cpu_gnt && bus.io_req;
      end
    end
  end

  assign addr_mux  = io_gnt ? bus.io_addr  : bus.cpu_addr;
  assign wdata_mux = io_gnt ? bus.io_wdata : bus.cpu_wdata;

  assign bus.io_gnt    = io_gnt;
  assign bus.cpu_stall = rst_n && bus.cpu_req && !cpu_gnt;
  assign bus.ram_we    = (cpu_gnt && bus.cpu_we) || (io_gnt && bus.io_we);
  assign bus.ram_addr  = addr_mux;
  assign bus.ram_wdata = wdata_mux;
  assign bus.cpu_rdata = bus.ram_rdata;
  assign bus.io_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a transaction-level ownership model checks the
// outputs every cycle, and literal expectations pin the specified scenarios.
module tb_ram_port_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int STARVE_LIMIT = 8;
  localparam int BURST_MAX    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  ram_port_arbiter #(
    .DW(DW), .AW(AW), .STARVE_LIMIT(STARVE_LIMIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data RAM driven by the DUT, plus the model's own shadow image
  logic [DW-1:0] mem    [4096];
  logic [DW-1:0] shadow [4096];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr[13:2]] <= bus.ram_wdata;
  assign bus.ram_rdata = mem[bus.ram_addr[13:2]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port, how many beats the current burst has used, how long I/O waited
  bit          m_locked = 0;
  int          m_beats  = 0;
  int          m_wait   = 0;
  bit          nx_locked;
  int          nx_beats, nx_wait, beats_now;
  bit          c_own, i_own, e_stall, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      c_own = 1'b0;
      i_own = 1'b0;
    end else if (m_locked) begin
      c_own = 1'b0;
      i_own = bus.io_req;
    end else begin
      c_own = bus.cpu_req && (m_wait < STARVE_LIMIT);
      i_own = !c_own && bus.io_req;
    end
    e_stall = rst_n && bus.cpu_req && !c_own;
    e_we    = (c_own && bus.cpu_we) || (i_own && bus.io_we);
    e_addr  = i_own ? bus.io_addr  : bus.cpu_addr;
    e_wdata = i_own ? bus.io_wdata : bus.cpu_wdata;

    chk("io_gnt",    64'(bus.io_gnt),    64'(i_own));
    chk("cpu_stall", 64'(bus.cpu_stall), 64'(e_stall));
    chk("ram_we",    64'(bus.ram_we),    64'(e_we));
    chk("ram_addr",  64'(bus.ram_addr),  64'(e_addr));
    if (e_we) chk("ram_wdata", 64'(bus.ram_wdata), 64'(e_wdata));
    chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(shadow[e_addr[13:2]]));
    chk("io_rdata",  64'(bus.io_rdata),  64'(shadow[e_addr[13:2]]));

    if (!rst_n) begin
      nx_locked = 1'b0;
      nx_beats  = 0;
      nx_wait   = 0;
    end else begin
      beats_now = m_beats + 1;
      nx_locked = i_own && !(bus.io_last || beats_now >= BURST_MAX);
      nx_beats  = nx_locked ? beats_now : 0;
      if (i_own || !bus.io_req) nx_wait = 0;
      else nx_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait;
    end
  end

  always @(posedge clk) begin
    m_locked <= nx_locked;
    m_beats  <= nx_beats;
    m_wait   <= nx_wait;
    if (rst_n && e_we) shadow[e_addr[13:2]] <= e_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_io(input logic req, input logic we, input logic last,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.io_req = req; bus.io_we = we; bus.io_last = last; bus.io_addr = a; bus.io_wdata = d;
  endtask

  int diffs;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    set_cpu(1'b1, 1'b1, 32'h10, 32'h5555_5555);
    set_io(1'b1, 1'b1, 1'b0, 32'h30, 32'h6666_6666);
    mid();
    chk("rst_io_gnt", 64'(bus.io_gnt), 64'(0));
    chk("rst_stall",  64'(bus.cpu_stall), 64'(0));
    chk("rst_ram_we", 64'(bus.ram_we), 64'(0));
    tick();
    set_cpu(1'b0, 1'b0, '0, '0);
    set_io(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    rst_n = 1'b1;

    // CPU-only store then load
    set_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    mid();
    chk("t1_stall", 64'(bus.cpu_stall), 64'(0));
    chk("t1_we",    64'(bus.ram_we), 64'(1));
    tick();
    set_cpu(1'b1, 1'b0, 32'h10, '0);
    mid();
    chk("t1_rdata", 64'(bus.cpu_rdata), 64'(32'hDEAD_BEEF));
    tick();

    // Idle CPU, 4-beat I/O write burst
    set_cpu(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      set_io(1'b1, 1'b1, 1'(i == 3), 32'(32'h20 + 4 * i), 32'(32'hA0 + i));
      mid();
      chk("t2_gnt", 64'(bus.io_gnt), 64'(1));
      tick();
    end
    set_io(1'b0, 1'b0, 1'b0, '0, '0);
    set_cpu(1'b1, 1'b0, 32'h2C, '0);
    mid();
    chk("t2_back_cpu", 64'(bus.cpu_stall), 64'(0));
    chk("t2_rdata",    64'(bus.cpu_rdata), 64'(32'hA3));
    tick();

    // Burst lock holds off the CPU until the last beat
    set_cpu(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      set_io(1'b1, 1'b1, 1'(i == 3), 32'(32'h40 + 4 * i), 32'(32'hB0 + i));
      if (i > 0) set_cpu(1'b1, 1'b0, 32'h10, '0);
      mid();
      chk("t3_gnt", 64'(bus.io_gnt), 64'(1));
      if (i > 0) chk("t3_stall", 64'(bus.cpu_stall), 64'(1));
      tick();
    end
    set_io(1'b0, 1'b0, 1'b0, '0, '0);
    mid();
    chk("t3_release", 64'(bus.cpu_stall), 64'(0));
    chk("t3_rdata",   64'(bus.cpu_rdata), 64'(32'hDEAD_BEEF));
    tick();

    // Starvation: I/O forced through on cycle STARVE_LIMIT+1
    set_cpu(1'b1, 1'b0, 32'h20, '0);
    set_io(1'b1, 1'b0, 1'b1, 32'h24, '0);
    for (int c = 1; c <= 9; c++) begin
      mid();
      chk("t4_gnt",   64'(bus.io_gnt),    64'(c == 9));
      chk("t4_stall", 64'(bus.cpu_stall), 64'(c == 9));
      if (c == 9) chk("t4_io_rdata", 64'(bus.io_rdata), 64'(32'hA1));
      else        chk("t4_cpu_rdata", 64'(bus.cpu_rdata), 64'(32'hA0));
      tick();
    end
    set_io(1'b0, 1'b0, 1'b0, '0, '0);
    mid();
    chk("t4_after", 64'(bus.cpu_stall), 64'(0));
    tick();

    // 20-beat burst: lock released after beat 16, CPU wins the next cycle
    set_cpu(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      set_io(1'b1, 1'b1, 1'(i == 19), 32'(32'h100 + 4 * i), 32'(32'h1000 + i));
      if (i == 16) begin
        set_cpu(1'b1, 1'b0, 32'h100, '0);
        mid();
        chk("t5_cpu_wins", 64'(bus.io_gnt),    64'(0));
        chk("t5_no_stall", 64'(bus.cpu_stall), 64'(0));
        chk("t5_rdata",    64'(bus.cpu_rdata), 64'(32'h1000));
        tick();
        set_cpu(1'b0, 1'b0, '0, '0);
      end
      mid();
      chk("t5_gnt", 64'(bus.io_gnt), 64'(1));
      tick();
    end
    set_io(1'b0, 1'b0, 1'b0, '0, '0);

    // Reset during beat 3 of a write burst
    for (int i = 0; i < 2; i++) begin
      set_io(1'b1, 1'b1, 1'b0, 32'(32'h200 + 4 * i), 32'(32'h2000 + i));
      mid();
      chk("t6_gnt", 64'(bus.io_gnt), 64'(1));
      tick();
    end
    set_io(1'b1, 1'b1, 1'b0, 32'h208, 32'h2002);
    set_cpu(1'b1, 1'b1, 32'h20C, 32'h7777_7777);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mid();
      chk("t6_rst_gnt",   64'(bus.io_gnt),    64'(0));
      chk("t6_rst_we",    64'(bus.ram_we),    64'(0));
      chk("t6_rst_stall", 64'(bus.cpu_stall), 64'(0));
      tick();
    end
    rst_n = 1'b1;
    set_io(1'b0, 1'b0, 1'b0, '0, '0);
    set_cpu(1'b1, 1'b0, 32'h208, '0);
    mid();
    chk("t6_stall", 64'(bus.cpu_stall), 64'(0));
    chk("t6_beat3", 64'(bus.cpu_rdata), 64'(0));
    tick();
    set_cpu(1'b1, 1'b0, 32'h204, '0);
    mid();
    chk("t6_beat2", 64'(bus.cpu_rdata), 64'(32'h2001));
    tick();
    set_cpu(1'b1, 1'b0, 32'h20C, '0);
    mid();
    chk("t6_cpu_wr", 64'(bus.cpu_rdata), 64'(0));
    tick();
    set_cpu(1'b0, 1'b0, '0, '0);
    tick();

    diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== shadow[i]) diffs++;
    chk("mem_image", 64'(diffs), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
